// File: rtl/fetch_to_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_to_decode_queue
//
// Bundle queue between the superscalar fetch and decode stages. It holds up
// to DEPTH fetch bundles of LANES instructions each, with a per-lane valid
// mask. The head entry is presented combinationally to decode
// (first-word fall-through). The minimum fetch-to-decode latency is one cycle
// because a bundle written at an edge becomes the head only after that edge.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset; the queue becomes empty
//   flush       synchronous discard of all entries (redirect); overrides
//               any push or pop in the same cycle
//   ValidF      fetch offers a bundle
//   ReadyF      queue has room; depends only on the registered occupancy
//   LaneValidF  per-lane valid of the offered bundle (all-zero is dropped)
//   PCF         PC of lane 0 of the offered bundle
//   InstrF      offered instructions, lane i at [i*XLEN +: XLEN]
//   ValidD      head bundle present
//   ReadyD      decode consumes the head bundle
//   LaneValidD  per-lane valid of the head bundle
//   PCD         per-lane PC of the head bundle (base + 4*i)
//   PCPlus4D    per-lane PC+4 of the head bundle (base + 4*(i+1))
//   InstrD      head instructions, with invalid lanes forced to zero
//   CountD      occupancy in bundles
// ---------------------------------------------------------------------------
module fetch_to_decode_queue #(
   parameter int LANES = 2,
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         ValidF,
   output logic                         ReadyF,
   input  logic [LANES-1:0]             LaneValidF,
   input  logic [XLEN-1:0]              PCF,
   input  logic [LANES*XLEN-1:0]        InstrF,
   output logic                         ValidD,
   input  logic                         ReadyD,
   output logic [LANES-1:0]             LaneValidD,
   output logic [LANES*XLEN-1:0]        PCD,
   output logic [LANES*XLEN-1:0]        PCPlus4D,
   output logic [LANES*XLEN-1:0]        InstrD,
   output logic [$clog2(DEPTH+1)-1:0]   CountD
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Entry storage. These registers are not reset: every output is gated by
   // ValidD, so stale contents are never observable.
   logic [XLEN-1:0]       pc_mem_q    [DEPTH];
   logic [LANES-1:0]      mask_mem_q  [DEPTH];
   logic [LANES*XLEN-1:0] instr_mem_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic ready_f_s;
   logic valid_d_s;
   logic push_s;
   logic pop_s;

   assign ready_f_s = (count_q < DEPTH_C);
   assign valid_d_s = (count_q != {CW{1'b0}});

   // An all-zero lane mask carries no work, so it is never stored.
   assign push_s = ValidF & ready_f_s & (|LaneValidF) & ~flush;
   assign pop_s  = valid_d_s & ReadyD & ~flush;

   assign ReadyF = ready_f_s;
   assign ValidD = valid_d_s;
   assign CountD = count_q;

   // Next-state for pointers and occupancy; flush wins over push and pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared immediately by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry write on an accepted push; the mask is stored exactly as given.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_q[wr_ptr_q]    <= PCF;
         mask_mem_q[wr_ptr_q]  <= LaneValidF;
         instr_mem_q[wr_ptr_q] <= InstrF;
      end
   end

   // Head-entry decode outputs: zero when empty; PCs are computed for every
   // lane but instructions of invalid lanes are forced to zero.
   always_comb begin
      LaneValidD = {LANES{1'b0}};
      PCD        = {(LANES*XLEN){1'b0}};
      PCPlus4D   = {(LANES*XLEN){1'b0}};
      InstrD     = {(LANES*XLEN){1'b0}};
      if (valid_d_s) begin
         LaneValidD = mask_mem_q[rd_ptr_q];
         for (int i = 0; i < LANES; i++) begin
            PCD[i*XLEN +: XLEN]      = pc_mem_q[rd_ptr_q] + XLEN'(4 * i);
            PCPlus4D[i*XLEN +: XLEN] = pc_mem_q[rd_ptr_q] + XLEN'(4 * (i + 1));
            if (mask_mem_q[rd_ptr_q][i]) begin
               InstrD[i*XLEN +: XLEN] = instr_mem_q[rd_ptr_q][i*XLEN +: XLEN];
            end else begin
               InstrD[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end
         end
      end else begin
         LaneValidD = {LANES{1'b0}};
         PCD        = {(LANES*XLEN){1'b0}};
         PCPlus4D   = {(LANES*XLEN){1'b0}};
         InstrD     = {(LANES*XLEN){1'b0}};
      end
   end

endmodule
